// File: rtl/mem_wb_stage.sv
// mem_wb_stage: stalls M until the data bus responds, extracts load data and registers the W stage
module mem_wb_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              valid_m,
    input  logic              memtoreg_m,
    input  logic              mem_write_m,
    input  logic              regwrite_m,
    input  logic [REG_W-1:0]  rd_m,
    input  logic [DATA_W-1:0] alu_out_m,
    input  logic [2:0]        load_type_m,
    input  logic              dresp_data_ok,
    input  logic [DATA_W-1:0] dresp_data,
    output logic              stall_m,
    output logic              valid_w,
    output logic              rf_we,
    output logic [REG_W-1:0]  rf_wa,
    output logic [DATA_W-1:0] rf_wd
);
    typedef enum logic {IDLE, WAIT} state_t;
    state_t state, state_nx;
    logic mem_op, advance;
    logic [7:0] ld_b;
    logic [15:0] ld_h;
    logic [DATA_W-1:0] ld_data;
    always_comb begin
        mem_op   = valid_m & (memtoreg_m | mem_write_m);
        stall_m  = resetn & ((state == WAIT) ? ~dresp_data_ok : (mem_op & ~dresp_data_ok));
        advance  = valid_m & ~stall_m;
        state_nx = (state == IDLE) ? ((mem_op & ~dresp_data_ok) ? WAIT : IDLE)
                                   : (dresp_data_ok ? IDLE : WAIT);
        ld_b     = dresp_data[{alu_out_m[1:0], 3'b000} +: 8];
        ld_h     = dresp_data[{alu_out_m[1], 4'b0000} +: 16];
        ld_data  = (load_type_m == 3'd1) ? {{(DATA_W-8){ld_b[7]}}, ld_b} :
                   (load_type_m == 3'd2) ? {{(DATA_W-8){1'b0}}, ld_b} :
                   (load_type_m == 3'd3) ? {{(DATA_W-16){ld_h[15]}}, ld_h} :
                   (load_type_m == 3'd4) ? {{(DATA_W-16){1'b0}}, ld_h} : dresp_data;
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            valid_w <= 1'b0;
            rf_we   <= 1'b0;
            rf_wa   <= '0;
            rf_wd   <= '0;
        end else begin
            state   <= state_nx;
            valid_w <= advance;
            rf_we   <= advance & regwrite_m & (rd_m != '0);
            if (advance) begin
                rf_wa <= rd_m;
                rf_wd <= memtoreg_m ? ld_data : alu_out_m;
            end
        end
    end
endmodule
